// File: rtl/lu_pkg.sv
// lu_pkg: shared constants for the load/store (LU) stage.
// Holds datapath widths used by the pipeline banks, mode and state encodings,
// and small mode-classification helpers.
package lu_pkg;

    localparam int DATA_SIZE         = 32;
    localparam int ROB_WIDTH         = 4;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int MODE_WIDTH        = 4;

    // Operation modes; codes 9..15 are treated as PASS.
    localparam logic [MODE_WIDTH-1:0] LU_MODE_PASS = 4'd0;
    localparam logic [MODE_WIDTH-1:0] LU_MODE_LW   = 4'd1;
    localparam logic [MODE_WIDTH-1:0] LU_MODE_LH   = 4'd2;
    localparam logic [MODE_WIDTH-1:0] LU_MODE_LHU  = 4'd3;
    localparam logic [MODE_WIDTH-1:0] LU_MODE_LB   = 4'd4;
    localparam logic [MODE_WIDTH-1:0] LU_MODE_LBU  = 4'd5;
    localparam logic [MODE_WIDTH-1:0] LU_MODE_SW   = 4'd6;
    localparam logic [MODE_WIDTH-1:0] LU_MODE_SH   = 4'd7;
    localparam logic [MODE_WIDTH-1:0] LU_MODE_SB   = 4'd8;

    typedef enum logic {
        LU_IDLE = 1'b0,
        LU_REQ  = 1'b1
    } lu_state_t;

    function automatic logic lu_is_load(input logic [MODE_WIDTH-1:0] mode);
        case (mode)
            LU_MODE_LW, LU_MODE_LH, LU_MODE_LHU, LU_MODE_LB, LU_MODE_LBU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic lu_is_store(input logic [MODE_WIDTH-1:0] mode);
        case (mode)
            LU_MODE_SW, LU_MODE_SH, LU_MODE_SB: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Word ops need both offset bits clear, halfword ops need bit 0 clear.
    function automatic logic lu_misaligned(input logic [MODE_WIDTH-1:0] mode,
                                           input logic [1:0]            off);
        case (mode)
            LU_MODE_LW, LU_MODE_SW:               return (off != 2'b00);
            LU_MODE_LH, LU_MODE_LHU, LU_MODE_SH:  return off[0];
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lu_align.sv
// lu_align: byte-lane steering for the LU stage (purely combinational).
// Request side: byte enables and lane-replicated store data for the incoming op.
// Response side: selects the addressed byte/half of the read word and extends it.
module lu_align #(
    parameter int DATA_SIZE  = 32,
    parameter int MODE_WIDTH = 4
) (
    input  logic [MODE_WIDTH-1:0] req_mode,
    input  logic [1:0]            req_off,
    input  logic [DATA_SIZE-1:0]  req_rs,
    output logic [3:0]            req_be,
    output logic [DATA_SIZE-1:0]  req_wdata,
    input  logic [MODE_WIDTH-1:0] rsp_mode,
    input  logic [1:0]            rsp_off,
    input  logic [DATA_SIZE-1:0]  rsp_rdata,
    output logic [DATA_SIZE-1:0]  rsp_data
);
    import lu_pkg::*;

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte enables and replicated write data for the request being accepted.
    always_comb begin
        req_be    = 4'b0000;
        req_wdata = {DATA_SIZE{1'b0}};
        case (req_mode)
            LU_MODE_LW, LU_MODE_SW:              req_be = 4'b1111;
            LU_MODE_LH, LU_MODE_LHU, LU_MODE_SH: req_be = 4'b0011 << {req_off[1], 1'b0};
            LU_MODE_LB, LU_MODE_LBU, LU_MODE_SB: req_be = 4'b0001 << req_off;
            default:                             req_be = 4'b0000;
        endcase
        case (req_mode)
            LU_MODE_SW: req_wdata = req_rs;
            LU_MODE_SH: req_wdata = {2{req_rs[15:0]}};
            LU_MODE_SB: req_wdata = {4{req_rs[7:0]}};
            default:    req_wdata = {DATA_SIZE{1'b0}};
        endcase
    end

    // Little-endian lane pick and sign/zero extension of the returned word;
    // stores and non-memory modes yield zero.
    always_comb begin
        byte_s   = rsp_rdata[{rsp_off, 3'b000} +: 8];
        half_s   = rsp_rdata[{rsp_off[1], 4'b0000} +: 16];
        rsp_data = {DATA_SIZE{1'b0}};
        case (rsp_mode)
            LU_MODE_LW:  rsp_data = rsp_rdata;
            LU_MODE_LH:  rsp_data = {{(DATA_SIZE-16){half_s[15]}}, half_s};
            LU_MODE_LHU: rsp_data = {{(DATA_SIZE-16){1'b0}}, half_s};
            LU_MODE_LB:  rsp_data = {{(DATA_SIZE-8){byte_s[7]}}, byte_s};
            LU_MODE_LBU: rsp_data = {{(DATA_SIZE-8){1'b0}}, byte_s};
            default:     rsp_data = {DATA_SIZE{1'b0}};
        endcase
    end

endmodule

// File: rtl/lu_stage.sv
// lu_stage: load/store stage downstream of the EX->LU bank.
// Accepts one instruction when idle, runs a req/ack data-memory access for
// load/store modes (stalling the bank meanwhile) and emits a one-cycle tagged
// writeback pulse. Non-memory modes complete the cycle after accept.
// Optional feature macro: LU_ALIGN_CHECK_EN -- misaligned word/half accesses
// skip memory and complete with wb_exc=1, wb_data=0.
module lu_stage #(
    parameter int DATA_SIZE         = 32,
    parameter int ROB_WIDTH         = 4,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int MODE_WIDTH        = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_LU,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_LU,
    input  logic [MODE_WIDTH-1:0]        mode_LU,
    input  logic [DATA_SIZE-1:0]         ALU_out_LU,
    input  logic [ROB_WIDTH-1:0]         tag_LU,
    input  logic [DATA_SIZE-1:0]         rs_bus_LU,
    output logic                         stall_LU,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [DATA_SIZE-1:0]         mem_addr,
    output logic [3:0]                   mem_be,
    output logic [DATA_SIZE-1:0]         mem_wdata,
    input  logic                         mem_ack,
    input  logic [DATA_SIZE-1:0]         mem_rdata,
    output logic                         wb_valid,
    output logic [ROB_WIDTH-1:0]         wb_tag,
    output logic [INSTRUCTION_WIDTH-1:0] wb_instruction,
    output logic [DATA_SIZE-1:0]         wb_data,
    output logic                         wb_exc
);
    import lu_pkg::*;

    lu_state_t                    state_r;
    logic [MODE_WIDTH-1:0]        mode_r;
    logic [1:0]                   off_r;
    logic [ROB_WIDTH-1:0]         tag_r;
    logic [INSTRUCTION_WIDTH-1:0] instr_r;

    logic                         mem_req_r;
    logic                         mem_we_r;
    logic [DATA_SIZE-1:0]         mem_addr_r;
    logic [3:0]                   mem_be_r;
    logic [DATA_SIZE-1:0]         mem_wdata_r;

    logic                         wb_valid_r;
    logic [ROB_WIDTH-1:0]         wb_tag_r;
    logic [INSTRUCTION_WIDTH-1:0] wb_instruction_r;
    logic [DATA_SIZE-1:0]         wb_data_r;
    logic                         wb_exc_r;

    logic                         is_mem_s;
    logic                         misalign_s;
    logic [3:0]                   be_s;
    logic [DATA_SIZE-1:0]         wdata_s;
    logic [DATA_SIZE-1:0]         load_data_s;

    assign is_mem_s = lu_is_load(mode_LU) || lu_is_store(mode_LU);

`ifdef LU_ALIGN_CHECK_EN
    assign misalign_s = lu_misaligned(mode_LU, ALU_out_LU[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    lu_align #(
        .DATA_SIZE  (DATA_SIZE),
        .MODE_WIDTH (MODE_WIDTH)
    ) u_align (
        .req_mode  (mode_LU),
        .req_off   (ALU_out_LU[1:0]),
        .req_rs    (rs_bus_LU),
        .req_be    (be_s),
        .req_wdata (wdata_s),
        .rsp_mode  (mode_r),
        .rsp_off   (off_r),
        .rsp_rdata (mem_rdata),
        .rsp_data  (load_data_s)
    );

    // Two-state accept/request FSM with registered memory and writeback outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= LU_IDLE;
            mode_r           <= {MODE_WIDTH{1'b0}};
            off_r            <= 2'b00;
            tag_r            <= {ROB_WIDTH{1'b0}};
            instr_r          <= {INSTRUCTION_WIDTH{1'b0}};
            mem_req_r        <= 1'b0;
            mem_we_r         <= 1'b0;
            mem_addr_r       <= {DATA_SIZE{1'b0}};
            mem_be_r         <= 4'b0000;
            mem_wdata_r      <= {DATA_SIZE{1'b0}};
            wb_valid_r       <= 1'b0;
            wb_tag_r         <= {ROB_WIDTH{1'b0}};
            wb_instruction_r <= {INSTRUCTION_WIDTH{1'b0}};
            wb_data_r        <= {DATA_SIZE{1'b0}};
            wb_exc_r         <= 1'b0;
        end else begin
            // Writeback is a single-cycle pulse unless a completion below re-arms it.
            wb_valid_r <= 1'b0;
            case (state_r)
                LU_IDLE: begin
                    // Any mem_ack seen here is stale (e.g. from an abandoned access).
                    if (valid_LU) begin
                        mode_r  <= mode_LU;
                        off_r   <= ALU_out_LU[1:0];
                        tag_r   <= tag_LU;
                        instr_r <= instruction_LU;
                        if (!is_mem_s || misalign_s) begin
                            wb_valid_r       <= 1'b1;
                            wb_tag_r         <= tag_LU;
                            wb_instruction_r <= instruction_LU;
                            wb_data_r        <= misalign_s ? {DATA_SIZE{1'b0}} : ALU_out_LU;
                            wb_exc_r         <= misalign_s;
                        end else begin
                            state_r     <= LU_REQ;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= lu_is_store(mode_LU);
                            mem_addr_r  <= {ALU_out_LU[DATA_SIZE-1:2], 2'b00};
                            mem_be_r    <= be_s;
                            mem_wdata_r <= wdata_s;
                        end
                    end
                end
                LU_REQ: begin
                    // Request fields stay frozen until the memory acknowledges.
                    if (mem_ack) begin
                        state_r          <= LU_IDLE;
                        mem_req_r        <= 1'b0;
                        wb_valid_r       <= 1'b1;
                        wb_tag_r         <= tag_r;
                        wb_instruction_r <= instr_r;
                        wb_data_r        <= load_data_s;
                        wb_exc_r         <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= LU_IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign stall_LU       = (state_r == LU_REQ);
    assign mem_req        = mem_req_r;
    assign mem_we         = mem_we_r;
    assign mem_addr       = mem_addr_r;
    assign mem_be         = mem_be_r;
    assign mem_wdata      = mem_wdata_r;
    assign wb_valid       = wb_valid_r;
    assign wb_tag         = wb_tag_r;
    assign wb_instruction = wb_instruction_r;
    assign wb_data        = wb_data_r;
    assign wb_exc         = wb_exc_r;

endmodule

// File: tb/tb_lu_stage.sv
// tb_lu_stage: randomized self-checking bench for lu_stage.
// The driver schedules each transaction (accept cycle, ack latency) and writes
// the expected per-cycle outputs into timeline arrays; one compare process
// checks the DUT against those arrays every cycle.
module tb_lu_stage;

    localparam int NCYC = 2600;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        valid_LU;
    logic [31:0] instruction_LU;
    logic [3:0]  mode_LU;
    logic [31:0] ALU_out_LU;
    logic [3:0]  tag_LU;
    logic [31:0] rs_bus_LU;
    logic        stall_LU;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic [31:0] wb_instruction;
    logic [31:0] wb_data;
    logic        wb_exc;

    lu_stage dut (
        .clk            (clk),
        .reset          (reset),
        .valid_LU       (valid_LU),
        .instruction_LU (instruction_LU),
        .mode_LU        (mode_LU),
        .ALU_out_LU     (ALU_out_LU),
        .tag_LU         (tag_LU),
        .rs_bus_LU      (rs_bus_LU),
        .stall_LU       (stall_LU),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .wb_valid       (wb_valid),
        .wb_tag         (wb_tag),
        .wb_instruction (wb_instruction),
        .wb_data        (wb_data),
        .wb_exc         (wb_exc)
    );

    // Cycle n is the interval following the n-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output timeline, indexed by cycle.
    logic        exp_stall [NCYC];
    logic        exp_req   [NCYC];
    logic [31:0] exp_addr  [NCYC];
    logic [3:0]  exp_be    [NCYC];
    logic        exp_we    [NCYC];
    logic [31:0] exp_wdata [NCYC];
    logic        exp_wbv   [NCYC];
    logic [3:0]  exp_tag   [NCYC];
    logic [31:0] exp_ins   [NCYC];
    logic [31:0] exp_data  [NCYC];
    logic        exp_exc   [NCYC];

    int          n_vec = 0;
    int          n_err = 0;
    bit          checking = 1'b0;
    int          next_free = 0;
    int          ack_cyc = -1;
    logic [31:0] pend_rd = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (specification arithmetic) ----------------
    function automatic int m_size(input logic [3:0] m);
        case (m)
            4'd1, 4'd6:       return 4;
            4'd2, 4'd3, 4'd7: return 2;
            4'd4, 4'd5, 4'd8: return 1;
            default:          return 0;
        endcase
    endfunction

    function automatic bit m_store(input logic [3:0] m);
        return (m >= 4'd6) && (m <= 4'd8);
    endfunction

    function automatic int m_off(input logic [3:0] m, input logic [31:0] a);
        int sz;
        sz = m_size(m);
        if (sz == 2) return 2 * int'(a[1]);
        if (sz == 1) return int'(a[1:0]);
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] m, input logic [31:0] a);
        int v;
        v = ((1 << m_size(m)) - 1) << m_off(m, a);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] m, input logic [31:0] rs);
        case (m_size(m))
            4:       return rs;
            2:       return {16'h0, rs[15:0]} * 32'h0001_0001;
            1:       return {24'h0, rs[7:0]} * 32'h0101_0101;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] m, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        if (m_store(m) || m_size(m) == 0) return 32'h0;
        v = rd >> (8 * m_off(m, a));
        if (m_size(m) == 2) begin
            v = v & 32'h0000_FFFF;
            if (m == 4'd2 && v[15]) v = v | 32'hFFFF_0000;
        end else if (m_size(m) == 1) begin
            v = v & 32'h0000_00FF;
            if (m == 4'd4 && v[7]) v = v | 32'hFFFF_FF00;
        end
        return v;
    endfunction

    function automatic bit m_misaligned(input logic [3:0] m, input logic [31:0] a);
`ifdef LU_ALIGN_CHECK_EN
        if (m_size(m) == 4) return a[1:0] != 2'b00;
        if (m_size(m) == 2) return a[0];
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_exp(input int n);
        exp_stall[n] = 1'b0; exp_req[n] = 1'b0; exp_addr[n] = 32'h0; exp_be[n] = 4'h0;
        exp_we[n] = 1'b0; exp_wdata[n] = 32'h0; exp_wbv[n] = 1'b0; exp_tag[n] = 4'h0;
        exp_ins[n] = 32'h0; exp_data[n] = 32'h0; exp_exc[n] = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        valid_LU       = 1'b0;
        mode_LU        = 4'($urandom);
        ALU_out_LU     = $urandom;
        tag_LU         = 4'($urandom);
        rs_bus_LU      = $urandom;
        instruction_LU = $urandom;
        mem_rdata      = $urandom;
        mem_ack        = 1'b0;
        if (cyc == ack_cyc) begin
            mem_ack   = 1'b1;
            mem_rdata = pend_rd;
        end else if (cyc >= next_free && $urandom_range(0, 7) == 0) begin
            mem_ack = 1'b1;
        end
    endtask

    // Present one instruction in the current cycle (the DUT is idle) and
    // record everything it must produce afterwards.
    task automatic issue(input logic [3:0] m, input logic [31:0] a, input logic [31:0] rs,
                         input logic [3:0] tg, input int k, input logic [31:0] rd);
        int t;
        t = cyc;
        valid_LU = 1'b1; mode_LU = m; ALU_out_LU = a; rs_bus_LU = rs; tag_LU = tg;
        instruction_LU = $urandom;
        if (m_size(m) == 0 || m_misaligned(m, a)) begin
            exp_wbv[t+1]  = 1'b1;
            exp_tag[t+1]  = tg;
            exp_ins[t+1]  = instruction_LU;
            exp_data[t+1] = (m_size(m) == 0) ? a : 32'h0;
            exp_exc[t+1]  = m_misaligned(m, a);
            next_free     = t + 1;
        end else begin
            for (int j = 1; j <= k; j++) begin
                exp_stall[t+j] = 1'b1;
                exp_req[t+j]   = 1'b1;
                exp_addr[t+j]  = a & 32'hFFFF_FFFC;
                exp_be[t+j]    = m_be(m, a);
                exp_we[t+j]    = m_store(m);
                exp_wdata[t+j] = m_wdata(m, rs);
            end
            ack_cyc         = t + k;
            pend_rd         = rd;
            exp_wbv[t+k+1]  = 1'b1;
            exp_tag[t+k+1]  = tg;
            exp_ins[t+k+1]  = instruction_LU;
            exp_data[t+k+1] = m_load(m, a, rd);
            exp_exc[t+k+1]  = 1'b0;
            next_free       = t + k + 1;
        end
    endtask

    task automatic run(input logic [3:0] m, input logic [31:0] a, input logic [31:0] rs,
                       input logic [3:0] tg, input int k, input logic [31:0] rd);
        next_cycle();
        while (cyc < next_free) next_cycle();
        issue(m, a, rs, tg, k, rd);
    endtask

    // Per-cycle comparison of every DUT output against the timeline.
    always @(negedge clk) begin
        if (checking && cyc < NCYC) begin
            chk("stall_LU", {31'h0, stall_LU}, {31'h0, exp_stall[cyc]});
            chk("mem_req", {31'h0, mem_req}, {31'h0, exp_req[cyc]});
            chk("wb_valid", {31'h0, wb_valid}, {31'h0, exp_wbv[cyc]});
            if (exp_req[cyc]) begin
                chk("mem_addr", mem_addr, exp_addr[cyc]);
                chk("mem_be", {28'h0, mem_be}, {28'h0, exp_be[cyc]});
                chk("mem_we", {31'h0, mem_we}, {31'h0, exp_we[cyc]});
                if (exp_we[cyc]) chk("mem_wdata", mem_wdata, exp_wdata[cyc]);
            end
            if (exp_wbv[cyc]) begin
                chk("wb_tag", {28'h0, wb_tag}, {28'h0, exp_tag[cyc]});
                chk("wb_instruction", wb_instruction, exp_ins[cyc]);
                chk("wb_data", wb_data, exp_data[cyc]);
                chk("wb_exc", {31'h0, wb_exc}, {31'h0, exp_exc[cyc]});
            end
        end
    end

    initial begin
        int t0;
        for (int n = 0; n < NCYC; n++) clear_exp(n);
        reset = 1'b1; valid_LU = 1'b0; mode_LU = 4'h0; ALU_out_LU = 32'h0; tag_LU = 4'h0;
        rs_bus_LU = 32'h0; instruction_LU = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

        // Hand-computed values that pin the reference model.
        chk("model_lb",   m_load(4'd4, 32'h103, 32'h80AA_BBCC), 32'hFFFF_FF80);
        chk("model_lbu",  m_load(4'd5, 32'h103, 32'h80AA_BBCC), 32'h0000_0080);
        chk("model_lh",   m_load(4'd2, 32'h102, 32'h80AA_BBCC), 32'hFFFF_80AA);
        chk("model_lhu",  m_load(4'd3, 32'h100, 32'h80AA_BBCC), 32'h0000_BBCC);
        chk("model_be_b", {28'h0, m_be(4'd4, 32'h103)}, 32'h0000_0008);
        chk("model_be_h", {28'h0, m_be(4'd7, 32'h202)}, 32'h0000_000C);
        chk("model_be_w", {28'h0, m_be(4'd1, 32'h101)}, 32'h0000_000F);
        chk("model_sh",   m_wdata(4'd7, 32'hDEAD_BEEF), 32'hBEEF_BEEF);
        chk("model_sb",   m_wdata(4'd8, 32'hDEAD_BEEF), 32'hEFEF_EFEF);

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'h0, stall_LU}, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst_wb_tag", {28'h0, wb_tag}, 32'h0);
        chk("rst_wb_ins", wb_instruction, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_wb_exc", {31'h0, wb_exc}, 32'h0);
        checking  = 1'b1;
        reset     = 1'b0;
        next_free = cyc + 1;

        // Directed cases.
        run(4'd0, 32'h1234_5678, 32'h0, 4'd3, 0, 32'h0);
        run(4'd4, 32'h0000_0103, 32'h0, 4'd5, 1, 32'h80AA_BBCC);
        run(4'd5, 32'h0000_0103, 32'h0, 4'd6, 1, 32'h80AA_BBCC);
        run(4'd7, 32'h0000_0202, 32'hDEAD_BEEF, 4'd7, 4, 32'h5555_AAAA);
        run(4'd1, 32'h0000_0101, 32'h0, 4'd8, 2, 32'hCAFE_F00D);
        run(4'd12, 32'hA5A5_0001, 32'h0, 4'd2, 0, 32'h0);
        run(4'd1, 32'h0000_0040, 32'h0, 4'd10, 1, 32'h0102_0304);
        run(4'd0, 32'h0BAD_CAFE, 32'h0, 4'd11, 0, 32'h0);
        run(4'd1, 32'h0000_0044, 32'h0, 4'd12, 1, 32'h0506_0708);

        // Reset in the middle of a request: access abandoned, late ack ignored.
        run(4'd1, 32'h0000_0300, 32'h0, 4'd9, 4, 32'h1111_2222);
        t0 = cyc;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        for (int j = 3; j <= 6; j++) clear_exp(t0 + j);
        ack_cyc   = -1;
        next_free = t0 + 6;
        next_cycle();
        reset   = 1'b0;
        mem_ack = 1'b1;
        chk("rst_req_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_req_stall", {31'h0, stall_LU}, 32'h0);
        chk("rst_req_wb_valid", {31'h0, wb_valid}, 32'h0);
        next_cycle();
        mem_ack = 1'b1;

        // Randomized traffic, biased toward memory operations.
        while (cyc < NCYC - 30) begin
            next_cycle();
            if (cyc >= next_free && $urandom_range(0, 3) != 0) begin
                logic [3:0]  m;
                logic [31:0] a;
                m = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(1, 8));
                a = $urandom;
                issue(m, a, $urandom, 4'($urandom), $urandom_range(1, 5), $urandom);
            end
        end

        // Drain outstanding work and a few idle cycles.
        while (cyc < next_free + 3) next_cycle();
        @(negedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lu_stage.md
# lu_stage

Load/store stage of the MIPS pipeline, directly downstream of the EX→LU register bank. It consumes the instruction, mode, effective address (ALU_out), ROB tag and store data (rs_bus) held in that bank. It performs the data-memory access through a req/ack handshake and stalls the bank while busy. It delivers a tagged, completed result to writeback/ROB.

## Interface
Parameters:
- DATA_SIZE, 32, datapath and address width.
- ROB_WIDTH, 4, ROB tag width.
- INSTRUCTION_WIDTH, 32, instruction code width.
- MODE_WIDTH, 4, operation-mode width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- valid_LU  in  1  bank holds a valid instruction.
- instruction_LU  in  INSTRUCTION_WIDTH  instruction code; passed through to writeback.
- mode_LU  in  MODE_WIDTH  operation select.
- ALU_out_LU  in  DATA_SIZE  effective address, or pass-through result.
- tag_LU  in  ROB_WIDTH  ROB tag.
- rs_bus_LU  in  DATA_SIZE  store data.
- stall_LU  out  1  upstream must hold; drives bank load = !stall_LU.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  DATA_SIZE  word-aligned address, {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  DATA_SIZE  lane-replicated store data.
- mem_ack  in  1  request complete; rdata valid this cycle.
- mem_rdata  in  DATA_SIZE  read word.
- wb_valid  out  1  one-cycle completion pulse.
- wb_tag  out  ROB_WIDTH  completed tag.
- wb_instruction  out  INSTRUCTION_WIDTH  completed instruction.
- wb_data  out  DATA_SIZE  result; 0 for stores.
- wb_exc  out  1  alignment exception; see Configuration.

## Operation
- Modes: 0 PASS, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB. Codes 9–15 behave as PASS.
- Accept: valid_LU && state==IDLE. Accept latches address, data, tag, instruction and mode.
- FSM states: IDLE, REQ.
  - IDLE + accept PASS: go to IDLE. Next cycle: wb_valid=1, wb_data=ALU_out.
  - IDLE + accept memory op: go to REQ.
  - REQ: mem_req=1, with addr, be, we and wdata held stable until mem_ack.
  - REQ + mem_ack: go to IDLE, register the result, wb_valid=1 next cycle.
- stall_LU = (state==REQ). It is combinational from state.
- Byte lanes are little-endian; off = addr[1:0].
- Byte enables:
  - LW/SW: mem_be = 1111.
  - LH/LHU/SH: mem_be = 0011 << {addr[1],1'b0}.
  - LB/LBU/SB: mem_be = 0001 << off.
- mem_wdata:
  - SW: rs.
  - SH: {2{rs[15:0]}}.
  - SB: {4{rs[7:0]}}.
- Load extraction:
  - LB: byte rdata[8*off+:8], sign-extended.
  - LBU: same byte, zero-extended.
  - LH: half rdata[16*addr[1]+:16], sign-extended.
  - LHU: same half, zero-extended.
- Stores complete with wb_valid=1 and wb_data=0 so the ROB retires them.
- Reset:
  - Outputs: state IDLE; stall_LU, mem_req, mem_we, mem_be, mem_addr, mem_wdata = 0; wb_valid, wb_tag, wb_instruction, wb_data, wb_exc = 0.
  - Mid-REQ reset abandons the access; mem_req is 0 the cycle after.
  - Any late mem_ack in IDLE is ignored.

## Timing
- PASS: accept at T, wb_valid at T+1. Back-to-back PASS gives 1/cycle throughput.
- Memory op: accept at T, mem_req from T+1. With ack at T+k (k≥1), wb_valid at T+k+1.
- stall_LU is high T+1..T+k. A new accept is possible at T+k+1.
- mem_ack in the same cycle mem_req first rises is legal (k=1).
- wb_valid is exactly one cycle per accepted instruction, never two in a row for a single instruction.

## Configuration
- LU_ALIGN_CHECK_EN defined:
  - A misaligned access is LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]=1.
  - No memory request is issued. The FSM stays IDLE and raises no stall.
  - Next cycle: wb_valid=1, wb_exc=1, wb_data=0.
- LU_ALIGN_CHECK_EN undefined:
  - wb_exc is tied to 0.
  - Unused low address bits are ignored: LW/SW act as aligned, halfword ops use addr[1] only.

## Structure
- Shared package lu_pkg holds:
  - mode encodings (LU_MODE_*);
  - state encodings (LU_IDLE, LU_REQ);
  - DATA_SIZE, ROB_WIDTH, INSTRUCTION_WIDTH and MODE_WIDTH, the same constants the pipeline banks use.
- One combinational sub-module, lu_align, computes mem_be and mem_wdata, and extracts and extends load data. lu_stage holds the FSM and registers.

## Test plan
- PASS mode 0, ALU_out=0x1234_5678, tag=3 → wb_valid at T+1, wb_data=0x1234_5678, wb_tag=3, no mem_req.
- LB at addr 0x103, rdata=0x80AA_BBCC, ack at k=1 → mem_addr=0x100, mem_be=1000, wb_data=0xFFFF_FF80 at T+2. LBU gives 0x0000_0080.
- SH at addr 0x202, rs=0xDEAD_BEEF, ack delayed k=4 → mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF stable for 4 cycles. stall_LU high T+1..T+4; wb_valid at T+5 with wb_data=0.
- LW at addr 0x101 with LU_ALIGN_CHECK_EN → no mem_req, wb_exc=1 at T+1. Without the macro → mem_addr=0x100, normal load.
- reset asserted while in REQ → next cycle mem_req=0, stall_LU=0, wb_valid=0. A subsequent mem_ack produces no writeback.
- Back-to-back LW, PASS, LW with ack k=1 → wb_valid pulses at T+2, T+3, T+5, in order, with correct tags.
